// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared types and constants for the key stream arbiter
package top_pkg;

  typedef logic [8:0] key_data_t;

  // Bit of a key beat that marks the final beat of a message
  localparam int key_last_idx = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } key_arb_state_t;

endpackage

// File: rtl/top_rr_pick.sv
// rtl/top_rr_pick.sv - combinational round-robin picker starting at a pointer
module top_rr_pick #(
  parameter int num_req_p = 4,
  parameter int idx_w_p   = 2
) (
  input  logic [num_req_p-1:0] i_req,
  input  logic [idx_w_p-1:0]   i_ptr,
  output logic [num_req_p-1:0] o_grant,
  output logic [idx_w_p-1:0]   o_idx,
  output logic                 o_any
);

  // One extra bit so ptr + offset never overflows before the wrap
  localparam logic [idx_w_p:0] c_n = (idx_w_p + 1)'(num_req_p);

  logic [idx_w_p:0] w_sum;

  // Scan ptr, ptr+1, ... modulo num_req_p and keep the first requester found
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      w_sum = {1'b0, i_ptr} + (idx_w_p + 1)'(k);
      if (w_sum >= c_n) begin
        w_sum = w_sum - c_n;
      end
      if (!o_any && i_req[w_sum[idx_w_p-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_sum[idx_w_p-1:0];
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/top_key_arb.sv
// rtl/top_key_arb.sv - round-robin message arbiter feeding the single key stream
module top_key_arb
  import top_pkg::*;
#(
  parameter int num_req_p   = 4,
  parameter int max_beats_p = 16
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_i,
  input  logic [num_req_p-1:0] req_valid_i,
  output logic [num_req_p-1:0] req_accept_o,
  input  logic [8:0]           req_data_i [0:num_req_p-1],
  output logic                 key_valid_o,
  input  logic                 key_accept_i,
  output logic [8:0]           key_data_o,
  output logic [num_req_p-1:0] grant_o,
  output logic                 busy_o,
  output logic                 forced_release_o
);

  localparam int idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int cnt_w = (max_beats_p > 0) ? $clog2(max_beats_p + 1) : 1;

  localparam logic [cnt_w:0]   c_limit    = (cnt_w + 1)'(max_beats_p);
  localparam logic [idx_w-1:0] c_last_idx = idx_w'(num_req_p - 1);
  localparam logic [cnt_w-1:0] c_cnt_max  = '1;

  key_arb_state_t       r_state;
  logic [idx_w-1:0]     r_idx;
  logic [idx_w-1:0]     r_ptr;
  logic [num_req_p-1:0] r_grant;
  logic [cnt_w-1:0]     r_beat_cnt;
  logic                 r_key_valid;
  key_data_t            r_key_data;
  logic                 r_forced;

  logic [num_req_p-1:0] w_pick_grant;
  logic [idx_w-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_can_load;
  logic [num_req_p-1:0] w_accept;
  logic                 w_up;
  key_data_t            w_beat;
  logic                 w_at_limit;
  logic                 w_end;
  logic                 w_forced;
  logic [idx_w-1:0]     w_next_ptr;

  top_rr_pick #(
    .num_req_p (num_req_p),
    .idx_w_p   (idx_w)
  ) u_pick (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // The output register can take a beat when empty or when it drains this cycle
  assign w_can_load = !r_key_valid || key_accept_i;

  // Only the owner may move a beat, and only while the output stage has room
  always_comb begin
    w_accept = '0;
    if (!main_rst_i && (r_state == LOCK) && w_can_load) begin
      w_accept = r_grant & req_valid_i;
    end
  end

  assign w_up       = |w_accept;
  assign w_beat     = req_data_i[r_idx];
  assign w_at_limit = (max_beats_p != 0) && (({1'b0, r_beat_cnt} + 1'b1) == c_limit);
  assign w_end      = w_up && (w_beat[key_last_idx] || w_at_limit);
  assign w_forced   = w_up && w_at_limit && !w_beat[key_last_idx];
  assign w_next_ptr = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

  // Arbitration FSM: pick in IDLE, hold the owner for a whole message in LOCK
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_state    <= LOCK;
            r_idx      <= w_pick_idx;
            r_grant    <= w_pick_grant;
            r_beat_cnt <= '0;
          end
        end
        LOCK: begin
          if (w_up) begin
            if (w_end) begin
              r_state    <= IDLE;
              r_grant    <= '0;
              r_ptr      <= w_next_ptr;
              r_beat_cnt <= '0;
            end else if (r_beat_cnt != c_cnt_max) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Output stage: load on upstream transfer, empty on a drain without a load
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      r_key_valid <= 1'b0;
      r_key_data  <= '0;
      r_forced    <= 1'b0;
    end else begin
      r_forced <= w_forced;
      if (w_up) begin
        r_key_valid <= 1'b1;
        r_key_data  <= w_beat;
        if (w_forced) begin
          r_key_data[key_last_idx] <= 1'b1;
        end
      end else if (r_key_valid && key_accept_i) begin
        r_key_valid <= 1'b0;
        r_key_data  <= '0;
      end
    end
  end

  assign req_accept_o     = w_accept;
  assign key_valid_o      = r_key_valid;
  assign key_data_o       = r_key_data;
  assign grant_o          = r_grant;
  assign busy_o           = (r_state == LOCK) || r_key_valid;
  assign forced_release_o = r_forced;

endmodule

// File: tb/tb_top_key_arb.sv
// tb/tb_top_key_arb.sv - randomized scoreboard bench for top_key_arb
module tb_top_key_arb;

  localparam int n_req = 4;
  localparam int lim   = 4;

  typedef struct packed {
    logic       forced;
    logic [8:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_accept;
  logic [8:0] req_data [0:3];
  logic       key_valid;
  logic       key_accept;
  logic [8:0] key_data;
  logic [3:0] grant;
  logic       busy;
  logic       forced_rel;

  always #5 clk = ~clk;

  top_key_arb #(.num_req_p(n_req), .max_beats_p(lim)) dut (
    .main_clk_i       (clk),
    .main_rst_i       (rst),
    .req_valid_i      (req_valid),
    .req_accept_o     (req_accept),
    .req_data_i       (req_data),
    .key_valid_o      (key_valid),
    .key_accept_i     (key_accept),
    .key_data_o       (key_data),
    .grant_o          (grant),
    .busy_o           (busy),
    .forced_release_o (forced_rel)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] src_q [4][$];
  exp_t       exp_q [4][$];
  int         grant_log[$];
  int         chunk_pos [4];
  int         seq [4];
  bit         hold [4];
  bit         xfer [4];
  int         valid_pct = 100;
  int         acc_pct = 100;
  int         exp_forced = 0;
  int         seen_forced = 0;
  int         exp_ptr = 0;
  int         cur_owner = -1;
  int         m_e;
  int         m_src;
  exp_t       m_x;
  logic [3:0] m_prev_grant = '0;
  logic [3:0] m_prev_valid = '0;
  logic       m_prev_kv = 1'b0;
  logic       m_prev_ka = 1'b0;
  logic [8:0] m_prev_data = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(logic [3:0] v, int p);
    for (int k = 0; k < n_req; k++) begin
      if (v[(p + k) % n_req]) return (p + k) % n_req;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(logic [3:0] g);
    for (int k = 0; k < n_req; k++) begin
      if (g[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int s = 0; s < n_req; s++) begin
      if (src_q[s].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference: a message is split into grants of at most lim beats; the beat
  // that hits the limit without its own last flag leaves with bit 8 set.
  task automatic push_msg(int s, int len);
    logic [8:0] d;
    exp_t       e;
    bit         last;
    for (int k = 0; k < len; k++) begin
      last = (k == len - 1);
      d = {last, 2'(s), 6'(seq[s])};
      seq[s] = (seq[s] + 1) % 64;
      e.forced = !last && (chunk_pos[s] == lim - 1);
      e.data = d | (e.forced ? 9'h100 : 9'h000);
      chunk_pos[s] = (last || e.forced) ? 0 : chunk_pos[s] + 1;
      src_q[s].push_back(d);
      exp_q[s].push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < n_req; s++) begin
      if (xfer[s]) void'(src_q[s].pop_front());
    end
    for (int s = 0; s < n_req; s++) begin
      if (src_q[s].size() != 0 && !hold[s] && ($urandom_range(99) < valid_pct)) begin
        req_valid[s] = 1'b1;
        req_data[s] = src_q[s][0];
      end else begin
        req_valid[s] = 1'b0;
        req_data[s] = 9'($urandom);
      end
    end
    key_accept = ($urandom_range(99) < acc_pct);
    @(negedge clk);
    for (int s = 0; s < n_req; s++) xfer[s] = req_valid[s] & req_accept[s];
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    key_accept = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_forced", forced_rel, 0);
    chk("rst_key_data", key_data, 0);
    chk("rst_busy", busy, 0);
    for (int s = 0; s < n_req; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
      chunk_pos[s] = 0;
      hold[s] = 1'b0;
      xfer[s] = 1'b0;
    end
    exp_forced = 0;
    seen_forced = 0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    for (int s = 0; s < n_req; s++) hold[s] = 1'b0;
    if (acc_pct < 20) acc_pct = 50;
    if (valid_pct < 20) valid_pct = 50;
    while ((pending() || key_valid || grant != 0) && budget < 3000) begin
      step();
      budget++;
    end
    chk("drain_done", budget < 3000, 1);
    for (int s = 0; s < n_req; s++) chk("exp_left", exp_q[s].size(), 0);
    chk("forced_count", seen_forced, exp_forced);
  endtask

  // Monitor: protocol rules every cycle, beats against the scoreboard on drain
  always @(negedge clk) begin
    if (rst) begin
      chk("acc_in_reset", req_accept, 0);
      exp_ptr = 0;
      cur_owner = -1;
      m_prev_grant = '0;
      m_prev_valid = '0;
      m_prev_kv = 1'b0;
      m_prev_ka = 1'b0;
      m_prev_data = '0;
    end else begin
      if (m_prev_grant == 0) begin
        m_e = first_from(m_prev_valid, exp_ptr);
        chk("grant_pick", grant, (m_e < 0) ? 0 : (1 << m_e));
        if (grant != 0) grant_log.push_back(onehot_idx(grant));
      end else if (grant == 0) begin
        exp_ptr = (onehot_idx(m_prev_grant) + 1) % n_req;
      end else begin
        chk("grant_held", grant, m_prev_grant);
      end
      chk("accept_rule", req_accept, (!key_valid || key_accept) ? (grant & req_valid) : 4'b0);
      chk("busy_rule", busy, (grant != 0) || key_valid);
      if (m_prev_kv && !m_prev_ka) begin
        chk("hold_valid", key_valid, 1);
        chk("hold_data", key_data, m_prev_data);
      end
      if (forced_rel) begin
        seen_forced++;
        chk("forced_beat", {key_valid, key_data[8]}, 2'b11);
        chk("forced_fresh", m_prev_kv && !m_prev_ka, 0);
      end
      if (key_valid && key_accept) begin
        m_src = int'(key_data[7:6]);
        if (exp_q[m_src].size() == 0) begin
          chk("unexpected_beat", key_data, 9'h000);
        end else begin
          m_x = exp_q[m_src].pop_front();
          chk("beat_data", key_data, m_x.data);
          if (m_x.forced) exp_forced++;
        end
        if (cur_owner >= 0) chk("no_interleave", m_src, cur_owner);
        cur_owner = key_data[8] ? -1 : m_src;
      end
      m_prev_grant = grant;
      m_prev_valid = req_valid;
      m_prev_kv = key_valid;
      m_prev_ka = key_accept;
      m_prev_data = key_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    key_accept = 1'b0;
    for (int s = 0; s < n_req; s++) begin
      req_data[s] = '0;
      seq[s] = 0;
      chunk_pos[s] = 0;
      hold[s] = 1'b0;
      xfer[s] = 1'b0;
    end
    repeat (2) @(posedge clk);
    do_reset();

    // Single source latency: beats 0x040, 0x041, 0x142 from requester 1
    valid_pct = 100;
    acc_pct = 100;
    push_msg(1, 3);
    step();
    chk("lat_c0_grant", grant, 4'b0000);
    step();
    chk("lat_c1_grant", grant, 4'b0010);
    chk("lat_c1_accept", req_accept, 4'b0010);
    step();
    chk("lat_c2_valid", key_valid, 1);
    chk("lat_c2_data", key_data, 9'h040);
    step();
    chk("lat_c3_data", key_data, 9'h041);
    step();
    chk("lat_c4_data", key_data, 9'h142);
    chk("lat_c4_idle", grant, 4'b0000);
    drain();

    // Fairness: every source always has a one-beat message waiting
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < n_req; s++) push_msg(s, 1);
    end
    drain();
    chk("fair_log_len", grant_log.size() >= 5, 1);
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("fair_order", grant_log[k], k % n_req);
    end

    // Beat limit: six beats from source 2 with source 3 waiting
    grant_log.delete();
    push_msg(2, 6);
    push_msg(3, 2);
    drain();

    // Backpressure: five cycles of key_accept low in mid-message
    push_msg(0, 3);
    push_msg(1, 3);
    repeat (3) step();
    acc_pct = 0;
    repeat (5) step();
    acc_pct = 100;
    drain();

    // Stalled owner keeps the grant while others wait
    do_reset();
    valid_pct = 100;
    acc_pct = 100;
    push_msg(1, 6);
    repeat (3) step();
    push_msg(0, 2);
    push_msg(2, 2);
    hold[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_grant", grant, 4'b0010);
    end
    hold[1] = 1'b0;
    drain();

    // Randomized traffic with random valid and accept duty cycles
    for (int r = 0; r < 4; r++) begin
      valid_pct = $urandom_range(100, 30);
      acc_pct = $urandom_range(100, 30);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(9) == 0) push_msg($urandom_range(n_req - 1), $urandom_range(7, 1));
        step();
      end
      drain();
    end

    // Reset in the middle of a message from source 3
    valid_pct = 100;
    acc_pct = 100;
    push_msg(1, 1);
    push_msg(3, 6);
    for (int k = 0; k < 50 && grant != 4'b1000; k++) step();
    chk("pre_rst_owner", grant, 4'b1000);
    repeat (3) step();
    do_reset();
    grant_log.delete();
    push_msg(0, 2);
    push_msg(2, 2);
    drain();
    chk("post_rst_log", grant_log.size() >= 1, 1);
    if (grant_log.size() >= 1) chk("post_rst_first", grant_log[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
